// File: rtl/ram_arb_pkg.sv
// ============================================================================
// Module  : ram_arb_pkg
// Brief   : Shared opcodes, command width and FSM encoding for ram_arbiter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package ram_arb_pkg;

    localparam int CMD_W = 10;

    localparam logic [1:0] OP_WR_ADDR = 2'b00;
    localparam logic [1:0] OP_WR_DATA = 2'b01;
    localparam logic [1:0] OP_RD_ADDR = 2'b10;
    localparam logic [1:0] OP_RD_DATA = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HOLD    = 2'd1,
        ST_WAIT_RD = 2'd2
    } arb_state_e;

    function automatic logic [1:0] cmd_opcode(input logic [CMD_W-1:0] cmd);
        return cmd[CMD_W-1 -: 2];
    endfunction

endpackage

`default_nettype wire

// File: rtl/ram_arb_timer.sv
// ============================================================================
// Module  : ram_arb_timer
// Brief   : Clear/enable cycle counter; expire_o flags the last allowed cycle.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module ram_arb_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    assign expire_o = en_i && (count_q == CNT_W'(TIMEOUT - 1));

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i && !expire_o) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/ram_arbiter.sv
// ============================================================================
// Module  : ram_arbiter
// Brief   : Two-requester arbiter for the single-port RAM; grants whole
//           address+data transactions and steers read data to the owner.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int DATA_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [9:0]        req0_cmd,
    input  logic              req0_valid,
    output logic              req0_ready,
    output logic [DATA_W-1:0] rsp0_data,
    output logic              rsp0_valid,
    input  logic [9:0]        req1_cmd,
    input  logic              req1_valid,
    output logic              req1_ready,
    output logic [DATA_W-1:0] rsp1_data,
    output logic              rsp1_valid,
    output logic [9:0]        ram_din,
    output logic              ram_rx_valid,
    input  logic [DATA_W-1:0] ram_dout,
    input  logic              ram_tx_valid,
    output logic              busy,
    output logic              owner,
    output logic              timeout_err
);

    arb_state_e        state_q, state_d;
    logic              owner_q, owner_d;
    logic              last_q, last_d;
    logic [9:0]        ram_din_q, ram_din_d;
    logic              ram_rx_valid_q, ram_rx_valid_d;
    logic [DATA_W-1:0] rsp0_data_q, rsp0_data_d;
    logic [DATA_W-1:0] rsp1_data_q, rsp1_data_d;
    logic              rsp0_valid_q, rsp0_valid_d;
    logic              rsp1_valid_q, rsp1_valid_d;
    logic              timeout_q, timeout_d;

    logic              w_win;
    logic              w_any;
    logic              w_rdy0;
    logic              w_rdy1;
    logic              w_acc0;
    logic              w_acc1;
    logic              w_acc;
    logic [9:0]        w_acc_cmd;
    logic [1:0]        w_acc_op;
    logic              w_rsp_fire;
    logic              w_tmr_clr;
    logic              w_tmr_en;
    logic              w_tmr_expire;

    // Round-robin: on a tie the requester that did not win last time goes.
    assign w_any = req0_valid | req1_valid;
    assign w_win = (req0_valid & req1_valid) ? ~last_q : req1_valid;

    always_comb begin
        w_rdy0 = 1'b0;
        w_rdy1 = 1'b0;
        case (state_q)
            ST_IDLE: begin
                w_rdy0 = w_any & ~w_win;
                w_rdy1 = w_any &  w_win;
            end
            ST_HOLD: begin
                w_rdy0 = ~owner_q;
                w_rdy1 =  owner_q;
            end
            default: begin
                w_rdy0 = 1'b0;
                w_rdy1 = 1'b0;
            end
        endcase
    end

    assign w_acc0    = req0_valid & w_rdy0;
    assign w_acc1    = req1_valid & w_rdy1;
    assign w_acc     = w_acc0 | w_acc1;
    assign w_acc_cmd = w_acc1 ? req1_cmd : req0_cmd;
    assign w_acc_op  = cmd_opcode(w_acc_cmd);
    assign w_rsp_fire = (state_q == ST_WAIT_RD) && ram_tx_valid;

    always_comb begin
        state_d        = state_q;
        owner_d        = owner_q;
        last_d         = last_q;
        ram_din_d      = ram_din_q;
        ram_rx_valid_d = 1'b0;
        rsp0_data_d    = rsp0_data_q;
        rsp1_data_d    = rsp1_data_q;
        rsp0_valid_d   = 1'b0;
        rsp1_valid_d   = 1'b0;
        timeout_d      = 1'b0;

        if (w_acc) begin
            ram_din_d      = w_acc_cmd;
            ram_rx_valid_d = 1'b1;
            owner_d        = w_acc1;
        end

        case (state_q)
            ST_IDLE: begin
                if (w_acc) begin
                    last_d = w_acc1;
                    case (w_acc_op)
                        OP_WR_ADDR: state_d = ST_HOLD;
                        OP_RD_ADDR: state_d = ST_HOLD;
                        OP_RD_DATA: state_d = ST_WAIT_RD;
                        default:    state_d = ST_IDLE;
                    endcase
                end
            end
            ST_HOLD: begin
                // An accept on the expiry cycle takes priority over the timeout.
                if (w_acc) begin
                    case (w_acc_op)
                        OP_WR_DATA: state_d = ST_IDLE;
                        OP_RD_DATA: state_d = ST_WAIT_RD;
                        default:    state_d = ST_HOLD;
                    endcase
                end else if (w_tmr_expire) begin
                    state_d   = ST_IDLE;
                    timeout_d = 1'b1;
                end
            end
            ST_WAIT_RD: begin
                if (w_rsp_fire) begin
                    state_d = ST_IDLE;
                    if (owner_q) begin
                        rsp1_data_d  = ram_dout;
                        rsp1_valid_d = 1'b1;
                    end else begin
                        rsp0_data_d  = ram_dout;
                        rsp0_valid_d = 1'b1;
                    end
                end else if (w_tmr_expire) begin
                    state_d   = ST_IDLE;
                    timeout_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign w_tmr_clr = w_acc || (state_d != state_q);
    assign w_tmr_en  = (state_q != ST_IDLE);

    ram_arb_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_i    (w_tmr_clr),
        .en_i     (w_tmr_en),
        .expire_o (w_tmr_expire)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            owner_q        <= 1'b0;
            last_q         <= 1'b1;
            ram_din_q      <= '0;
            ram_rx_valid_q <= 1'b0;
            rsp0_data_q    <= '0;
            rsp1_data_q    <= '0;
            rsp0_valid_q   <= 1'b0;
            rsp1_valid_q   <= 1'b0;
            timeout_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            owner_q        <= owner_d;
            last_q         <= last_d;
            ram_din_q      <= ram_din_d;
            ram_rx_valid_q <= ram_rx_valid_d;
            rsp0_data_q    <= rsp0_data_d;
            rsp1_data_q    <= rsp1_data_d;
            rsp0_valid_q   <= rsp0_valid_d;
            rsp1_valid_q   <= rsp1_valid_d;
            timeout_q      <= timeout_d;
        end
    end

    // Readies are combinational, so they are forced low while reset is held.
    assign req0_ready   = rst_n & w_rdy0;
    assign req1_ready   = rst_n & w_rdy1;
    assign rsp0_data    = rsp0_data_q;
    assign rsp1_data    = rsp1_data_q;
    assign rsp0_valid   = rsp0_valid_q;
    assign rsp1_valid   = rsp1_valid_q;
    assign ram_din      = ram_din_q;
    assign ram_rx_valid = ram_rx_valid_q;
    assign busy         = (state_q != ST_IDLE);
    assign owner        = owner_q;
    assign timeout_err  = timeout_q;

endmodule

`default_nettype wire

// File: tb/tb_ram_arbiter.sv
// ============================================================================
// Module  : tb_ram_arbiter
// Brief   : Randomised scoreboard bench for ram_arbiter with a transaction-level
//           reference model of ownership, round-robin and timeouts.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ram_arbiter;
    import ram_arb_pkg::*;

    localparam int TIMEOUT = 16;
    localparam int DATA_W  = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [1:0]        drv_valid = 2'b00;
    logic [9:0]        drv_cmd [2];
    logic              req0_ready, req1_ready;
    logic [DATA_W-1:0] rsp0_data, rsp1_data;
    logic              rsp0_valid, rsp1_valid;
    logic [9:0]        ram_din;
    logic              ram_rx_valid;
    logic [DATA_W-1:0] tx_data = '0;
    logic              tx_valid = 1'b0;
    logic              busy, owner, timeout_err;

    always #5 clk = ~clk;

    ram_arbiter #(.TIMEOUT(TIMEOUT), .DATA_W(DATA_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req0_cmd     (drv_cmd[0]),
        .req0_valid   (drv_valid[0]),
        .req0_ready   (req0_ready),
        .rsp0_data    (rsp0_data),
        .rsp0_valid   (rsp0_valid),
        .req1_cmd     (drv_cmd[1]),
        .req1_valid   (drv_valid[1]),
        .req1_ready   (req1_ready),
        .rsp1_data    (rsp1_data),
        .rsp1_valid   (rsp1_valid),
        .ram_din      (ram_din),
        .ram_rx_valid (ram_rx_valid),
        .ram_dout     (tx_data),
        .ram_tx_valid (tx_valid),
        .busy         (busy),
        .owner        (owner),
        .timeout_err  (timeout_err)
    );

    typedef struct { logic [9:0] cmd; int gap; } item_t;

    item_t script0[$];
    item_t script1[$];
    item_t cur [2];
    bit    have [2];
    int    cnt [2];

    logic [9:0]        din_q[$];
    logic [DATA_W-1:0] rsp0_q[$];
    logic [DATA_W-1:0] rsp1_q[$];
    int                te_q[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Reference model: who holds the RAM, whether a read is outstanding,
    // round-robin memory and cycles since the last event.
    int         lock;
    bit         rdwait;
    bit         rd_new;
    bit         last;
    bit         mowner;
    int         tmr;
    int         rdcnt;
    logic [1:0] acc;
    int         force_data = -1;
    int         force_delay = -1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic unexpected(input string name, input logic [31:0] act);
        checks++;
        errors++;
        $display("FAIL %s actual=%0h expected=none t=%0t", name, act, $time);
    endtask

    // Scoreboard monitor: pops an expectation whenever the DUT presents output.
    always @(negedge clk) begin
        if (rst_n) begin
            if (ram_rx_valid) begin
                if (din_q.size() == 0) unexpected("ram_din_spurious", ram_din);
                else chk("ram_din", ram_din, din_q.pop_front());
            end
            if (rsp0_valid) begin
                if (rsp0_q.size() == 0) unexpected("rsp0_spurious", rsp0_data);
                else chk("rsp0_data", rsp0_data, rsp0_q.pop_front());
            end
            if (rsp1_valid) begin
                if (rsp1_q.size() == 0) unexpected("rsp1_spurious", rsp1_data);
                else chk("rsp1_data", rsp1_data, rsp1_q.pop_front());
            end
            if (timeout_err) begin
                if (te_q.size() == 0) unexpected("timeout_spurious", cyc);
                else chk("timeout_cycle", cyc, te_q.pop_front());
            end
        end
    end

    task automatic add(input int r, input logic [1:0] op, input logic [7:0] pl, input int gap);
        item_t it;
        it.cmd = {op, pl};
        it.gap = gap;
        if (r == 0) script0.push_back(it);
        else script1.push_back(it);
    endtask

    function automatic int rand_gap();
        return ($urandom_range(0, 9) == 0) ? int'($urandom_range(13, 18)) : int'($urandom_range(0, 2));
    endfunction

    task automatic gen(input int r, input int n);
        for (int i = 0; i < n; i++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3: begin
                    add(r, OP_WR_ADDR, 8'($urandom), rand_gap());
                    add(r, OP_WR_DATA, 8'($urandom), rand_gap());
                end
                4, 5, 6: begin
                    add(r, OP_RD_ADDR, 8'($urandom), rand_gap());
                    add(r, OP_RD_DATA, 8'($urandom), rand_gap());
                end
                7: add(r, OP_WR_DATA, 8'($urandom), rand_gap());
                8: add(r, OP_RD_DATA, 8'($urandom), rand_gap());
                default: add(r, OP_RD_ADDR, 8'($urandom), rand_gap());
            endcase
        end
    endtask

    task automatic model_reset();
        lock = -1; rdwait = 0; rd_new = 0; last = 1'b1; mowner = 1'b0;
        tmr = 0; rdcnt = 0; acc = 2'b00;
        have[0] = 0; have[1] = 0; cnt[0] = 0; cnt[1] = 0;
        drv_valid = 2'b00; tx_valid = 1'b0;
        script0.delete(); script1.delete();
        din_q.delete(); rsp0_q.delete(); rsp1_q.delete(); te_q.delete();
    endtask

    // Evaluated between edges: predicts readies and the effect of the next edge.
    task automatic neg_step();
        logic [1:0] er;
        logic [1:0] op;
        int w;
        er = 2'b00;
        w = -1;
        if (!rdwait) begin
            if (lock >= 0) w = lock;
            else if (drv_valid == 2'b11) w = last ? 0 : 1;
            else if (drv_valid[0]) w = 0;
            else if (drv_valid[1]) w = 1;
            if (w >= 0) er[w] = 1'b1;
        end
        chk("busy", busy, (lock >= 0) || rdwait);
        chk("owner", owner, mowner);
        chk("ready0", req0_ready, er[0]);
        chk("ready1", req1_ready, er[1]);
        acc = 2'b00;
        if (w >= 0 && drv_valid[w]) begin
            acc[w] = 1'b1;
            op = drv_cmd[w][9:8];
            din_q.push_back(drv_cmd[w]);
            mowner = w[0];
            if (lock < 0) last = w[0];
            tmr = 0;
            if (op == OP_WR_DATA) lock = -1;
            else if (op == OP_RD_DATA) begin lock = -1; rdwait = 1; rd_new = 1; end
            else lock = w;
        end else if (rdwait && tx_valid) begin
            if (mowner) rsp1_q.push_back(tx_data);
            else rsp0_q.push_back(tx_data);
            rdwait = 0;
        end else if (lock >= 0 || rdwait) begin
            if (tmr == TIMEOUT - 1) begin
                te_q.push_back(cyc + 1);
                lock = -1;
                rdwait = 0;
            end else begin
                tmr++;
            end
        end
    endtask

    task automatic drive_req(input int r);
        if (acc[r]) have[r] = 0;
        if (!have[r]) begin
            if (r == 0 && script0.size() > 0) begin
                cur[r] = script0.pop_front(); have[r] = 1; cnt[r] = cur[r].gap;
            end else if (r == 1 && script1.size() > 0) begin
                cur[r] = script1.pop_front(); have[r] = 1; cnt[r] = cur[r].gap;
            end
        end
        if (have[r] && cnt[r] == 0) begin
            drv_valid[r] = 1'b1;
            drv_cmd[r]   = cur[r].cmd;
        end else begin
            drv_valid[r] = 1'b0;
            if (have[r]) cnt[r]--;
        end
    endtask

    task automatic pos_step();
        drive_req(0);
        drive_req(1);
        tx_valid = 1'b0;
        if (rdwait) begin
            if (rd_new) begin
                if (force_delay >= 0) rdcnt = force_delay;
                else rdcnt = ($urandom_range(0, 7) == 0) ? int'($urandom_range(12, 20)) : int'($urandom_range(0, 4));
                rd_new = 0;
            end
            if (rdcnt == 0) begin
                tx_valid = 1'b1;
                tx_data  = (force_data >= 0) ? DATA_W'(force_data) : DATA_W'($urandom);
            end else begin
                rdcnt--;
            end
        end else if ($urandom_range(0, 15) == 0) begin
            tx_valid = 1'b1;
            tx_data  = DATA_W'($urandom);
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        neg_step();
        @(posedge clk);
        #1;
        pos_step();
    endtask

    task automatic run_until_idle(input int maxc);
        int n;
        n = 0;
        while (n < maxc && !(script0.size() == 0 && script1.size() == 0 && !have[0] && !have[1]
                             && lock < 0 && !rdwait)) begin
            cycle();
            n++;
        end
        if (n >= maxc) unexpected("run_bound", n);
        repeat (4) cycle();
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_ram_din"}, ram_din, 0);
        chk({tag, "_ram_rx_valid"}, ram_rx_valid, 0);
        chk({tag, "_rsp0_data"}, rsp0_data, 0);
        chk({tag, "_rsp1_data"}, rsp1_data, 0);
        chk({tag, "_rsp0_valid"}, rsp0_valid, 0);
        chk({tag, "_rsp1_valid"}, rsp1_valid, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_owner"}, owner, 0);
        chk({tag, "_timeout_err"}, timeout_err, 0);
        chk({tag, "_ready0"}, req0_ready, 0);
        chk({tag, "_ready1"}, req1_ready, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        drv_cmd[0] = 10'h0A5;
        drv_cmd[1] = 10'h0B6;
        drv_valid  = 2'b11;
        #23;
        check_all_zero("reset");
        model_reset();
        #4;
        rst_n = 1'b1;

        // Tie after reset: req0 first, then alternation.
        add(0, OP_WR_ADDR, 8'hA5, 0); add(0, OP_WR_DATA, 8'h3C, 0);
        add(0, OP_WR_ADDR, 8'hC1, 0); add(0, OP_WR_DATA, 8'h55, 0);
        add(1, OP_WR_ADDR, 8'hB6, 0); add(1, OP_WR_DATA, 8'h4D, 0);
        add(1, OP_WR_ADDR, 8'hD2, 0); add(1, OP_WR_DATA, 8'h66, 0);
        run_until_idle(200);

        // Write pair then readback on req0.
        force_data = 8'h3C;
        add(0, OP_WR_ADDR, 8'hA5, 0); add(0, OP_WR_DATA, 8'h3C, 0);
        add(0, OP_RD_ADDR, 8'hA5, 0); add(0, OP_RD_DATA, 8'h00, 0);
        run_until_idle(200);

        // Read steering to req1.
        force_data = 8'h5E;
        add(1, OP_RD_ADDR, 8'hA5, 0); add(1, OP_RD_DATA, 8'h00, 0);
        run_until_idle(200);
        force_data = -1;

        // Abandoned pair times out; pending req1 goes next.
        add(0, OP_WR_ADDR, 8'hA5, 0); add(0, OP_WR_DATA, 8'h3C, 20);
        add(1, OP_WR_ADDR, 8'h11, 2); add(1, OP_WR_DATA, 8'h22, 0);
        run_until_idle(300);

        // Closing command lands exactly on the expiry cycle.
        add(0, OP_WR_ADDR, 8'h77, 0); add(0, OP_WR_DATA, 8'h88, TIMEOUT - 1);
        run_until_idle(300);

        // Read response lands exactly on the expiry cycle.
        force_delay = TIMEOUT - 1;
        add(1, OP_RD_ADDR, 8'h12, 0); add(1, OP_RD_DATA, 8'h00, 0);
        run_until_idle(300);
        force_delay = -1;

        gen(0, 40);
        gen(1, 40);
        run_until_idle(6000);

        // Asynchronous reset while waiting for read data.
        force_data  = 8'hE7;
        force_delay = 10;
        add(0, OP_RD_ADDR, 8'h21, 0); add(0, OP_RD_DATA, 8'h00, 0);
        for (int i = 0; i < 100 && !rdwait; i++) cycle();
        chk("reached_wait_rd", busy, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("midreset");
        model_reset();
        force_data  = -1;
        force_delay = -1;
        #3;
        rst_n = 1'b1;
        add(0, OP_WR_ADDR, 8'hA5, 0); add(0, OP_WR_DATA, 8'h3C, 0);
        add(1, OP_WR_ADDR, 8'hB6, 0); add(1, OP_WR_DATA, 8'h4D, 0);
        run_until_idle(200);

        repeat (TIMEOUT + 4) cycle();
        chk("din_q_drained", din_q.size(), 0);
        chk("rsp0_q_drained", rsp0_q.size(), 0);
        chk("rsp1_q_drained", rsp1_q.size(), 0);
        chk("te_q_drained", te_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
